// File: rtl/array_heap_if.sv
// Request/response bundle between a requester and array_heap.
interface array_heap_if #(
    parameter int unsigned ADDRESS_BITS = 2,
    parameter int unsigned INDEX_BITS   = 3,
    parameter int unsigned DATA_BITS    = 12
);
    logic                    i_start;
    logic [7:0]              i_action;
    logic [ADDRESS_BITS-1:0] i_array;
    logic [INDEX_BITS-1:0]   i_index;
    logic [DATA_BITS-1:0]    i_in;
    logic                    o_busy;
    logic                    o_done;
    logic [DATA_BITS-1:0]    o_out;
    logic [31:0]             o_error;

    modport master (
        output i_start, i_action, i_array, i_index, i_in,
        input  o_busy, o_done, o_out, o_error
    );

    modport slave (
        input  i_start, i_action, i_array, i_index, i_in,
        output o_busy, o_done, o_out, o_error
    );
endinterface

// File: rtl/array_heap.sv
// Pool of fixed-length arrays with allocate/free, stack/list edits and
// linear scans, served one request at a time through a start/done handshake.
module array_heap #(
    parameter int unsigned ADDRESS_BITS = 2,
    parameter int unsigned INDEX_BITS   = 3,
    parameter int unsigned DATA_BITS    = 12
) (
    input  logic        i_clock,
    input  logic        i_reset,
    array_heap_if.slave bus
);
    localparam int unsigned ARRAYS       = 2**ADDRESS_BITS;
    localparam int unsigned ARRAY_LENGTH = 2**INDEX_BITS;
    localparam int unsigned SIZE_BITS    = INDEX_BITS + 1;
    localparam int unsigned SP_BITS      = ADDRESS_BITS + 1;

    localparam logic [7:0] ACT_RESET   = 8'd1;
    localparam logic [7:0] ACT_WRITE   = 8'd2;
    localparam logic [7:0] ACT_READ    = 8'd3;
    localparam logic [7:0] ACT_SIZE    = 8'd4;
    localparam logic [7:0] ACT_INDEX   = 8'd7;
    localparam logic [7:0] ACT_LESS    = 8'd8;
    localparam logic [7:0] ACT_GREATER = 8'd9;
    localparam logic [7:0] ACT_UP      = 8'd10;
    localparam logic [7:0] ACT_DOWN    = 8'd11;
    localparam logic [7:0] ACT_PUSH    = 8'd14;
    localparam logic [7:0] ACT_POP     = 8'd15;
    localparam logic [7:0] ACT_ALLOC   = 8'd18;
    localparam logic [7:0] ACT_FREE    = 8'd19;

    localparam logic [31:0] ERR_NONE   = 32'd0;
    localparam logic [31:0] ERR_ACTION = 32'd1;
    localparam logic [31:0] ERR_ALLOC  = 32'd2;
    localparam logic [31:0] ERR_INDEX  = 32'd3;
    localparam logic [31:0] ERR_FULL   = 32'd4;
    localparam logic [31:0] ERR_EMPTY  = 32'd5;
    localparam logic [31:0] ERR_NOFREE = 32'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_busy;
    logic                    r_done;
    logic [DATA_BITS-1:0]    r_out;
    logic [31:0]             r_error;
    logic [7:0]              r_action;
    logic [ADDRESS_BITS-1:0] r_array;
    logic [INDEX_BITS-1:0]   r_index;
    logic [DATA_BITS-1:0]    r_in;
    logic [SIZE_BITS-1:0]    r_cnt;
    logic [SIZE_BITS-1:0]    r_acc;
    logic                    r_found;

    logic [DATA_BITS-1:0]    r_mem   [ARRAYS][ARRAY_LENGTH];
    logic [SIZE_BITS-1:0]    r_size  [ARRAYS];
    logic [ARRAYS-1:0]       r_alloc;
    logic [ADDRESS_BITS-1:0] r_stack [ARRAYS];
    logic [SP_BITS-1:0]      r_sp;

    logic [SIZE_BITS-1:0]    w_size;
    logic                    w_alloc;
    logic [SIZE_BITS-1:0]    w_idx_ext;
    logic [ADDRESS_BITS-1:0] w_top;
    logic [DATA_BITS-1:0]    w_old [ARRAY_LENGTH];
    logic [DATA_BITS-1:0]    w_row [ARRAY_LENGTH];
    logic [31:0]             w_err;
    logic [DATA_BITS-1:0]    w_out;
    logic                    w_mem_we;
    logic                    w_scan_req;

    logic [DATA_BITS-1:0]    w_elem;
    logic                    w_in_range;
    logic [SIZE_BITS-1:0]    w_acc;
    logic                    w_found;
    logic [SIZE_BITS-1:0]    w_scan_res;
    logic [31:0]             w_scan_err;

    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;
    assign bus.o_out   = r_out;
    assign bus.o_error = r_error;

    assign w_scan_req = (bus.i_action == ACT_INDEX) || (bus.i_action == ACT_LESS) ||
                        (bus.i_action == ACT_GREATER);

    // Views of the target array, its size/allocation and the free-stack top.
    always_comb begin
        w_size    = r_size[r_array];
        w_alloc   = r_alloc[r_array];
        w_idx_ext = SIZE_BITS'(r_index);
        w_top     = r_stack[ADDRESS_BITS'(r_sp - SP_BITS'(1))];
        for (int unsigned i = 0; i < ARRAY_LENGTH; i++) begin
            w_old[i] = r_mem[r_array][i];
        end
    end

    // Single-step op: ordered error checks, result and new row contents.
    always_comb begin
        w_err    = ERR_NONE;
        w_out    = '0;
        w_mem_we = 1'b0;
        for (int unsigned i = 0; i < ARRAY_LENGTH; i++) begin
            w_row[i] = w_old[i];
        end

        case (r_action)
            ACT_RESET, ACT_WRITE, ACT_READ, ACT_SIZE, ACT_INDEX, ACT_LESS,
            ACT_GREATER, ACT_UP, ACT_DOWN, ACT_PUSH, ACT_POP, ACT_ALLOC,
            ACT_FREE: w_err = ERR_NONE;
            default:  w_err = ERR_ACTION;
        endcase

        if (w_err == ERR_NONE && r_action != ACT_RESET && r_action != ACT_ALLOC && !w_alloc) begin
            w_err = ERR_ALLOC;
        end

        if (w_err == ERR_NONE) begin
            case (r_action)
                ACT_WRITE, ACT_READ, ACT_DOWN: if (w_idx_ext >= w_size) w_err = ERR_INDEX;
                ACT_UP:                        if (w_idx_ext > w_size)  w_err = ERR_INDEX;
                default: ;
            endcase
        end

        if (w_err == ERR_NONE) begin
            case (r_action)
                ACT_PUSH, ACT_UP: if (w_size == SIZE_BITS'(ARRAY_LENGTH)) w_err = ERR_FULL;
                ACT_POP, ACT_DOWN: if (w_size == '0) w_err = ERR_EMPTY;
                ACT_ALLOC: if (r_sp == '0) w_err = ERR_NOFREE;
                default: ;
            endcase
        end

        if (w_err == ERR_NONE) begin
            case (r_action)
                ACT_WRITE: begin
                    w_row[r_index] = r_in;
                    w_mem_we       = 1'b1;
                end
                ACT_READ: w_out = w_old[r_index];
                ACT_SIZE: w_out = DATA_BITS'(w_size);
                ACT_PUSH: begin
                    w_row[w_size[INDEX_BITS-1:0]] = r_in;
                    w_mem_we = 1'b1;
                    w_out    = r_in;
                end
                ACT_POP: w_out = w_old[INDEX_BITS'(w_size - SIZE_BITS'(1))];
                ACT_UP: begin
                    // Slots above the insertion point move up; anything past
                    // the old size is don't-care so the whole tail shifts.
                    for (int unsigned i = 1; i < ARRAY_LENGTH; i++) begin
                        if (INDEX_BITS'(i) > r_index) w_row[i] = w_old[i-1];
                    end
                    w_row[r_index] = r_in;
                    w_mem_we = 1'b1;
                    w_out    = r_in;
                end
                ACT_DOWN: begin
                    w_out = w_old[r_index];
                    for (int unsigned i = 0; i < ARRAY_LENGTH - 1; i++) begin
                        if (INDEX_BITS'(i) >= r_index) w_row[i] = w_old[i+1];
                    end
                    w_mem_we = 1'b1;
                end
                ACT_ALLOC: w_out = DATA_BITS'(w_top);
                default: ;
            endcase
        end
    end

    // Scan step: fold the element at r_cnt into the running count / match.
    always_comb begin
        w_elem     = r_mem[r_array][r_cnt[INDEX_BITS-1:0]];
        w_in_range = (r_cnt < w_size);
        w_acc      = r_acc;
        w_found    = r_found;
        case (r_action)
            ACT_LESS:    if (w_in_range && w_elem < r_in) w_acc = r_acc + SIZE_BITS'(1);
            ACT_GREATER: if (w_in_range && w_elem > r_in) w_acc = r_acc + SIZE_BITS'(1);
            default: begin
                if (!r_found && w_in_range && w_elem == r_in) begin
                    w_found = 1'b1;
                    w_acc   = r_cnt;
                end
            end
        endcase
        w_scan_err = w_alloc ? ERR_NONE : ERR_ALLOC;
        if (r_action == ACT_INDEX) begin
            w_scan_res = w_found ? w_acc : w_size;
        end else begin
            w_scan_res = w_acc;
        end
    end

    // Element storage: no reset, written only by successful edit ops.
    always_ff @(posedge i_clock) begin
        if (r_state == S_EXEC && w_mem_we) begin
            for (int unsigned i = 0; i < ARRAY_LENGTH; i++) begin
                r_mem[r_array][i] <= w_row[i];
            end
        end
    end

    // Control FSM plus size, allocation and free-stack bookkeeping.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_out    <= '0;
            r_error  <= '0;
            r_action <= '0;
            r_array  <= '0;
            r_index  <= '0;
            r_in     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_found  <= 1'b0;
            r_alloc  <= '0;
            r_sp     <= SP_BITS'(ARRAYS);
            for (int unsigned a = 0; a < ARRAYS; a++) begin
                r_size[a]  <= '0;
                r_stack[a] <= ADDRESS_BITS'(ARRAYS - 1 - a);
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_action <= bus.i_action;
                        r_array  <= bus.i_array;
                        r_index  <= bus.i_index;
                        r_in     <= bus.i_in;
                        r_error  <= '0;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_found  <= 1'b0;
                        r_state  <= w_scan_req ? S_SCAN : S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_out   <= w_out;
                    r_error <= w_err;
                    r_state <= S_DONE;
                    if (w_err == ERR_NONE) begin
                        case (r_action)
                            ACT_RESET: begin
                                r_alloc <= '0;
                                r_sp    <= SP_BITS'(ARRAYS);
                                for (int unsigned a = 0; a < ARRAYS; a++) begin
                                    r_size[a]  <= '0;
                                    r_stack[a] <= ADDRESS_BITS'(ARRAYS - 1 - a);
                                end
                            end
                            ACT_PUSH, ACT_UP: r_size[r_array] <= w_size + SIZE_BITS'(1);
                            ACT_POP, ACT_DOWN: r_size[r_array] <= w_size - SIZE_BITS'(1);
                            ACT_ALLOC: begin
                                r_alloc[w_top] <= 1'b1;
                                r_size[w_top]  <= '0;
                                r_sp           <= r_sp - SP_BITS'(1);
                            end
                            ACT_FREE: begin
                                r_alloc[r_array]                <= 1'b0;
                                r_size[r_array]                 <= '0;
                                r_stack[ADDRESS_BITS'(r_sp)]    <= r_array;
                                r_sp                            <= r_sp + SP_BITS'(1);
                            end
                            default: ;
                        endcase
                    end
                end
                S_SCAN: begin
                    r_cnt   <= r_cnt + SIZE_BITS'(1);
                    r_acc   <= w_acc;
                    r_found <= w_found;
                    if (r_cnt == SIZE_BITS'(ARRAY_LENGTH - 1)) begin
                        r_error <= w_scan_err;
                        r_out   <= (w_scan_err == ERR_NONE) ? DATA_BITS'(w_scan_res) : '0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_array_heap.sv
// Directed bench for array_heap with an expected-result queue.
module tb_array_heap;
    localparam int unsigned AB = 2;
    localparam int unsigned IB = 3;
    localparam int unsigned DB = 12;

    localparam logic [7:0] A_RESET   = 8'd1;
    localparam logic [7:0] A_WRITE   = 8'd2;
    localparam logic [7:0] A_READ    = 8'd3;
    localparam logic [7:0] A_SIZE    = 8'd4;
    localparam logic [7:0] A_INDEX   = 8'd7;
    localparam logic [7:0] A_LESS    = 8'd8;
    localparam logic [7:0] A_GREATER = 8'd9;
    localparam logic [7:0] A_UP      = 8'd10;
    localparam logic [7:0] A_DOWN    = 8'd11;
    localparam logic [7:0] A_PUSH    = 8'd14;
    localparam logic [7:0] A_POP     = 8'd15;
    localparam logic [7:0] A_ALLOC   = 8'd18;
    localparam logic [7:0] A_FREE    = 8'd19;

    localparam int LAT1 = 2;
    localparam int LATS = 9;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    array_heap_if #(.ADDRESS_BITS(AB), .INDEX_BITS(IB), .DATA_BITS(DB)) bus ();

    array_heap #(.ADDRESS_BITS(AB), .INDEX_BITS(IB), .DATA_BITS(DB)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int q_out[$];
    int q_err[$];
    bit q_chk[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic sb_push(input int eo, input int ee, input bit ec);
        q_out.push_back(eo);
        q_err.push_back(ee);
        q_chk.push_back(ec);
    endtask

    task automatic sb_compare(input string tag);
        int eo;
        int ee;
        bit ec;
        check({tag, "/sb_pending"}, 32'(q_out.size() > 0), 32'd1);
        if (q_out.size() > 0) begin
            eo = q_out.pop_front();
            ee = q_err.pop_front();
            ec = q_chk.pop_front();
            check({tag, "/error"}, bus.o_error, 32'(ee));
            if (ec) check({tag, "/out"}, 32'(bus.o_out), 32'(eo));
        end
    endtask

    task automatic op(input string tag, input logic [7:0] act, input int arr, input int idx,
                      input int din, input int exp_out, input int exp_err, input bit chk_out,
                      input int exp_lat);
        int cyc;
        sb_push(exp_out, exp_err, chk_out);
        @(negedge clk);
        bus.i_start  = 1'b1;
        bus.i_action = act;
        bus.i_array  = AB'(arr);
        bus.i_index  = IB'(idx);
        bus.i_in     = DB'(din);
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        check({tag, "/busy"}, 32'(bus.o_busy), 32'd1);
        cyc = 0;
        while (bus.o_done !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "/done"}, 32'(bus.o_done), 32'd1);
        check({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
        sb_compare(tag);
    endtask

    initial begin
        int dones;

        rst          = 1'b1;
        bus.i_start  = 1'b0;
        bus.i_action = '0;
        bus.i_array  = '0;
        bus.i_index  = '0;
        bus.i_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/busy", 32'(bus.o_busy), 32'd0);
        check("reset/done", 32'(bus.o_done), 32'd0);
        check("reset/out", 32'(bus.o_out), 32'd0);
        check("reset/error", bus.o_error, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Allocation order, exhaustion and LIFO reuse
        for (int k = 0; k < 4; k++) op("alloc", A_ALLOC, 0, 0, 0, k, 0, 1'b1, LAT1);
        op("alloc_none", A_ALLOC, 0, 0, 0, 0, 6, 1'b1, LAT1);
        op("free2", A_FREE, 2, 0, 0, 0, 0, 1'b0, LAT1);
        op("realloc2", A_ALLOC, 0, 0, 0, 2, 0, 1'b1, LAT1);

        // Reset action returns the pool to power-up state
        op("act_reset", A_RESET, 0, 0, 0, 0, 0, 1'b1, LAT1);
        op("alloc_a0", A_ALLOC, 0, 0, 0, 0, 0, 1'b1, LAT1);
        op("alloc_a1", A_ALLOC, 0, 0, 0, 1, 0, 1'b1, LAT1);

        // a0 = [5,9,3] and scans
        op("push5", A_PUSH, 0, 0, 5, 5, 0, 1'b1, LAT1);
        op("push9", A_PUSH, 0, 0, 9, 9, 0, 1'b1, LAT1);
        op("push3", A_PUSH, 0, 0, 3, 3, 0, 1'b1, LAT1);
        op("size3", A_SIZE, 0, 0, 0, 3, 0, 1'b1, LAT1);
        op("less6", A_LESS, 0, 0, 6, 2, 0, 1'b1, LATS);
        op("greater3", A_GREATER, 0, 0, 3, 2, 0, 1'b1, LATS);
        op("index9", A_INDEX, 0, 0, 9, 1, 0, 1'b1, LATS);
        op("index7", A_INDEX, 0, 0, 7, 3, 0, 1'b1, LATS);
        op("write_oob", A_WRITE, 0, 3, 1, 0, 3, 1'b1, LAT1);

        // Insert and remove in the middle
        op("up1", A_UP, 0, 1, 4, 0, 0, 1'b0, LAT1);
        op("size_up", A_SIZE, 0, 0, 0, 4, 0, 1'b1, LAT1);
        op("rd_up0", A_READ, 0, 0, 0, 5, 0, 1'b1, LAT1);
        op("rd_up1", A_READ, 0, 1, 0, 4, 0, 1'b1, LAT1);
        op("rd_up2", A_READ, 0, 2, 0, 9, 0, 1'b1, LAT1);
        op("rd_up3", A_READ, 0, 3, 0, 3, 0, 1'b1, LAT1);
        op("down0", A_DOWN, 0, 0, 0, 5, 0, 1'b1, LAT1);
        op("size_dn", A_SIZE, 0, 0, 0, 3, 0, 1'b1, LAT1);
        op("rd_dn0", A_READ, 0, 0, 0, 4, 0, 1'b1, LAT1);
        op("rd_dn1", A_READ, 0, 1, 0, 9, 0, 1'b1, LAT1);
        op("rd_dn2", A_READ, 0, 2, 0, 3, 0, 1'b1, LAT1);
        op("write1", A_WRITE, 0, 1, 77, 0, 0, 1'b0, LAT1);
        op("rd_w1", A_READ, 0, 1, 0, 77, 0, 1'b1, LAT1);
        op("less_strict", A_LESS, 0, 0, 4, 1, 0, 1'b1, LATS);

        // a1 fill to capacity, overflow, drain, underflow
        for (int k = 0; k < 8; k++) begin
            op("fill_push", A_PUSH, 1, 0, 10 + k, 10 + k, 0, 1'b1, LAT1);
            op("fill_size", A_SIZE, 1, 0, 0, k + 1, 0, 1'b1, LAT1);
        end
        op("push_full", A_PUSH, 1, 0, 99, 0, 4, 1'b1, LAT1);
        op("size_full", A_SIZE, 1, 0, 0, 8, 0, 1'b1, LAT1);
        op("index_miss_full", A_INDEX, 1, 0, 99, 8, 0, 1'b1, LATS);
        for (int k = 0; k < 8; k++) op("drain_pop", A_POP, 1, 0, 0, 17 - k, 0, 1'b1, LAT1);
        op("pop_empty", A_POP, 1, 0, 0, 0, 5, 1'b1, LAT1);
        op("size_empty", A_SIZE, 1, 0, 0, 0, 0, 1'b1, LAT1);
        op("read_empty", A_READ, 1, 0, 0, 0, 3, 1'b1, LAT1);

        // Unallocated array and unknown action
        op("read_unalloc", A_READ, 3, 0, 0, 0, 2, 1'b1, LAT1);
        op("free_unalloc", A_FREE, 3, 0, 0, 0, 2, 1'b1, LAT1);
        op("bad_action", 8'd99, 0, 0, 0, 0, 1, 1'b1, LAT1);

        // start held high: one done per accepted request
        for (int k = 0; k < 3; k++) sb_push(3, 0, 1'b1);
        dones = 0;
        @(negedge clk);
        bus.i_start  = 1'b1;
        bus.i_action = A_SIZE;
        bus.i_array  = AB'(0);
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_done === 1'b1) begin
                dones++;
                sb_compare("held");
            end
        end
        bus.i_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_done === 1'b1) dones++;
        end
        check("held/done_count", 32'(dones), 32'd3);

        // Reset during a scan aborts it without a done pulse
        @(negedge clk);
        bus.i_start  = 1'b1;
        bus.i_action = A_LESS;
        bus.i_array  = AB'(0);
        bus.i_in     = DB'(6);
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        check("abort/busy_before", 32'(bus.o_busy), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort/busy", 32'(bus.o_busy), 32'd0);
        check("abort/done", 32'(bus.o_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_done === 1'b1) dones++;
        end
        check("abort/no_done", 32'(dones), 32'd0);
        op("alloc_after_reset", A_ALLOC, 0, 0, 0, 0, 0, 1'b1, LAT1);
        check("sb/drained", 32'(q_out.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
